// File: rtl/tdisto_accum_if.sv
// Handshake bundle between the paired 4x4 weighted-transform stages, the
// distortion accumulator and the mode-decision logic that consumes its result.
interface tdisto_accum_if;
  logic               start;
  logic [15:0]        tlambda;
  logic signed [31:0] sum_a;
  logic               done_a;
  logic signed [31:0] sum_b;
  logic               done_b;
  logic               busy;
  logic [31:0]        disto;
  logic               disto_valid;
  logic               err;

  modport master (
    output start, tlambda, sum_a, done_a, sum_b, done_b,
    input  busy, disto, disto_valid, err
  );

  modport slave (
    input  start, tlambda, sum_a, done_a, sum_b, done_b,
    output busy, disto, disto_valid, err
  );
endinterface

// File: rtl/tdisto_accum.sv
// Spectral distortion accumulator: pairs source/reconstruction transform sums,
// accumulates |a - b| >> 5 per block, then scales the total by tlambda.
module tdisto_accum #(
  parameter int BLOCK_NUM = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  tdisto_accum_if.slave bus
);

  localparam int PROD_W = ACC_WIDTH + 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  // Magnitude of the 33-bit difference, shifted so the result truncates toward zero.
  function automatic logic [31:0] abs_shift5(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [32:0] diff;
    logic [32:0]        mag;
    diff = $signed({a[31], a}) - $signed({b[31], b});
    if (diff[32]) begin
      mag = 33'(-diff);
    end else begin
      mag = 33'(diff);
    end
    return 32'(mag >> 5);
  endfunction

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [31:0]          inc);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, acc} + (ACC_WIDTH + 1)'(inc);
    if (sum[ACC_WIDTH]) begin
      return {ACC_WIDTH{1'b1}};
    end else begin
      return sum[ACC_WIDTH-1:0];
    end
  endfunction

  logic [1:0]           state_q, state_d;
  logic [15:0]          tlambda_q, tlambda_d;
  logic signed [31:0]   sum_a_q, sum_a_d;
  logic signed [31:0]   sum_b_q, sum_b_d;
  logic                 pend_a_q, pend_a_d;
  logic                 pend_b_q, pend_b_d;
  logic [31:0]          abs_q, abs_d;
  logic                 abs_vld_q, abs_vld_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [6:0]           cnt_q, cnt_d;
  logic [PROD_W-1:0]    prod_q, prod_d;
  logic [31:0]          disto_q, disto_d;
  logic                 disto_valid_q, disto_valid_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;

  logic                 consume_s;
  logic [PROD_W:0]      rnd_s;
  logic [PROD_W-8:0]    scaled_s;
  logic [31:0]          disto_sat_s;

  // Round-to-nearest of prod / 256, clamped to the 32-bit result range.
  always_comb begin
    rnd_s    = {1'b0, prod_q} + (PROD_W + 1)'(9'd128);
    scaled_s = (PROD_W - 7)'(rnd_s >> 8);
    if (scaled_s > (PROD_W - 7)'(32'hFFFF_FFFF)) begin
      disto_sat_s = 32'hFFFF_FFFF;
    end else begin
      disto_sat_s = scaled_s[31:0];
    end
  end

  // Next-state logic: capture, pair, accumulate, scale, present.
  always_comb begin
    state_d       = state_q;
    tlambda_d     = tlambda_q;
    sum_a_d       = sum_a_q;
    sum_b_d       = sum_b_q;
    pend_a_d      = pend_a_q;
    pend_b_d      = pend_b_q;
    abs_d         = abs_q;
    abs_vld_d     = 1'b0;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    prod_d        = prod_q;
    disto_d       = disto_q;
    disto_valid_d = 1'b0;
    err_d         = err_q;
    consume_s     = 1'b0;

    if (bus.start) begin
      // Start wins in every state, so an in-flight run never reports a result.
      state_d   = S_ACC;
      tlambda_d = bus.tlambda;
      pend_a_d  = 1'b0;
      pend_b_d  = 1'b0;
      abs_d     = 32'd0;
      acc_d     = {ACC_WIDTH{1'b0}};
      cnt_d     = 7'd0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_ACC: begin
          consume_s = pend_a_q & pend_b_q;
          if (consume_s) begin
            abs_d     = abs_shift5(sum_a_q, sum_b_q);
            abs_vld_d = 1'b1;
          end else begin
            abs_d = abs_q;
          end

          if (bus.done_a) begin
            if (pend_a_q && !consume_s) begin
              err_d    = 1'b1;
              pend_a_d = 1'b1;
            end else begin
              sum_a_d  = bus.sum_a;
              pend_a_d = 1'b1;
            end
          end else begin
            pend_a_d = pend_a_q & ~consume_s;
          end

          if (bus.done_b) begin
            if (pend_b_q && !consume_s) begin
              err_d    = 1'b1;
              pend_b_d = 1'b1;
            end else begin
              sum_b_d  = bus.sum_b;
              pend_b_d = 1'b1;
            end
          end else begin
            pend_b_d = pend_b_q & ~consume_s;
          end

          if (abs_vld_q) begin
            acc_d = sat_add(acc_q, abs_q);
            cnt_d = cnt_q + 7'd1;
            if (cnt_q == 7'(BLOCK_NUM - 1)) begin
              state_d = S_MUL;
            end else begin
              state_d = S_ACC;
            end
          end else begin
            state_d = S_ACC;
          end
        end
        S_MUL: begin
          prod_d  = PROD_W'(acc_q) * PROD_W'(tlambda_q);
          state_d = S_OUT;
        end
        S_OUT: begin
          disto_d       = disto_sat_s;
          disto_valid_d = 1'b1;
          state_d       = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Held through the result cycle so busy drops one cycle after disto_valid.
    busy_d = (state_d != S_IDLE) || (state_q == S_OUT);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      tlambda_q     <= 16'd0;
      sum_a_q       <= 32'sd0;
      sum_b_q       <= 32'sd0;
      pend_a_q      <= 1'b0;
      pend_b_q      <= 1'b0;
      abs_q         <= 32'd0;
      abs_vld_q     <= 1'b0;
      acc_q         <= {ACC_WIDTH{1'b0}};
      cnt_q         <= 7'd0;
      prod_q        <= {PROD_W{1'b0}};
      disto_q       <= 32'd0;
      disto_valid_q <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tlambda_q     <= tlambda_d;
      sum_a_q       <= sum_a_d;
      sum_b_q       <= sum_b_d;
      pend_a_q      <= pend_a_d;
      pend_b_q      <= pend_b_d;
      abs_q         <= abs_d;
      abs_vld_q     <= abs_vld_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      prod_q        <= prod_d;
      disto_q       <= disto_d;
      disto_valid_q <= disto_valid_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.disto       = disto_q;
  assign bus.disto_valid = disto_valid_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_tdisto_accum.sv
// Self-checking bench for tdisto_accum: constant-pair vector table, hand-built
// multi-cycle sequences and randomized jobs against an arithmetic model.
module tb_tdisto_accum;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdisto_accum_if bus ();

  tdisto_accum #(.BLOCK_NUM(16), .ACC_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string  nm;
    int     a;
    int     b;
    int     tl;
    longint exp;
  } vec_t;

  vec_t vecs[11];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   valid_cnt = 0;
  int   qa[$];
  int   qb[$];

  always @(posedge clk) begin
    if (bus.disto_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic start_job(input int tl);
    bus.start   = 1'b1;
    bus.tlambda = 16'(tl);
    tick();
    bus.start   = 1'b0;
    bus.tlambda = 16'($urandom);
    chk("busy_rise", {63'd0, bus.busy}, 64'd1);
    chk("err_clear", {63'd0, bus.err}, 64'd0);
  endtask

  task automatic send(input bit da, input bit db, input int a, input int b);
    bus.done_a = da;
    bus.done_b = db;
    bus.sum_a  = a;
    bus.sum_b  = b;
    tick();
    bus.done_a = 1'b0;
    bus.done_b = 1'b0;
    bus.sum_a  = int'($urandom);
    bus.sum_b  = int'($urandom);
  endtask

  // Called right after the cycle holding the last done pulse.
  task automatic wait_result(input string nm, input longint exp_d, input bit exp_err);
    int lat = 0;
    while (bus.disto_valid !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd4);
    chk({nm, "_disto"}, {32'd0, bus.disto}, 64'(exp_d));
    chk({nm, "_err"}, {63'd0, bus.err}, {63'd0, exp_err});
    chk({nm, "_busy_at_valid"}, {63'd0, bus.busy}, 64'd1);
    tick();
    chk({nm, "_valid_pulse"}, {63'd0, bus.disto_valid}, 64'd0);
    chk({nm, "_busy_fall"}, {63'd0, bus.busy}, 64'd0);
  endtask

  function automatic longint model_disto(input longint tl);
    longint acc = 0;
    longint d;
    longint r;
    foreach (qa[i]) begin
      d = longint'(qa[i]) - longint'(qb[i]);
      if (d < 0) d = -d;
      acc += d / 32;
      if (acc > 64'sh0_FFFF_FFFF) acc = 64'sh0_FFFF_FFFF;
    end
    r = (acc * tl + 128) / 256;
    if (r > 64'sh0_FFFF_FFFF) r = 64'sh0_FFFF_FFFF;
    return r;
  endfunction

  initial begin
    int v0;
    int a;
    int b;
    int tl;

    vecs[0]  = '{"const",     1000,                 360,                  256,   320};
    vecs[1]  = '{"neg_round", -100,                 100,                  100,   38};
    vecs[2]  = '{"sat",       int'(32'h7FFF_FFFF),  int'(32'h8000_0000),  65535, 64'hFFFF_FFFF};
    vecs[3]  = '{"zero",      10,                   10,                   256,   0};
    vecs[4]  = '{"trunc31",   31,                   0,                    256,   0};
    vecs[5]  = '{"unit",      0,                    32,                   1,     0};
    vecs[6]  = '{"neg64",     -64,                  0,                    128,   16};
    vecs[7]  = '{"sym500",    500,                  -500,                 3,     6};
    vecs[8]  = '{"tl0",       1000,                 360,                  0,     0};
    vecs[9]  = '{"round_up",  100,                  -100,                 4,     2};
    vecs[10] = '{"neg_trunc", -33,                  0,                    256,   16};

    bus.start = 1'b0; bus.tlambda = 16'd0; bus.sum_a = 0; bus.sum_b = 0;
    bus.done_a = 1'b0; bus.done_b = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_disto", {32'd0, bus.disto}, 64'd0);
    chk("rst_valid", {63'd0, bus.disto_valid}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_err", {63'd0, bus.err}, 64'd0);
    rst_n = 1'b1;
    send(1'b1, 1'b1, 1000, 0);
    chk("idle_ignores_done", {63'd0, bus.busy}, 64'd0);

    for (int v = 0; v < 11; v++) begin
      start_job(vecs[v].tl);
      for (int i = 0; i < 16; i++) send(1'b1, 1'b1, vecs[v].a, vecs[v].b);
      wait_result(vecs[v].nm, vecs[v].exp, 1'b0);
    end

    // Last pair staggered: done_b three cycles after done_a.
    start_job(256);
    for (int i = 0; i < 15; i++) send(1'b1, 1'b1, 1000, 360);
    send(1'b1, 1'b0, 2000, 0);
    tick();
    tick();
    send(1'b0, 1'b1, 0, 0);
    wait_result("stagger", 362, 1'b0);

    // Second done_a before any done_b is dropped and flags err.
    start_job(256);
    send(1'b1, 1'b0, 1000, 0);
    send(1'b1, 1'b0, 5000, 0);
    chk("overrun_err_now", {63'd0, bus.err}, 64'd1);
    send(1'b0, 1'b1, 0, 360);
    for (int i = 0; i < 15; i++) send(1'b1, 1'b1, 1000, 360);
    wait_result("overrun", 320, 1'b1);

    // Abort after 7 pairs, then a full fresh run.
    v0 = valid_cnt;
    start_job(256);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b1, 1000, 0);
    start_job(256);
    for (int i = 0; i < 16; i++) send(1'b1, 1'b1, 320, 0);
    wait_result("abort7", 160, 1'b0);
    chk("abort7_one_valid", 64'(valid_cnt - v0), 64'd1);

    // Abort while the finished run sits in its output stage.
    v0 = valid_cnt;
    start_job(256);
    for (int i = 0; i < 16; i++) send(1'b1, 1'b1, 1000, 0);
    tick();
    tick();
    tick();
    start_job(256);
    chk("abort_out_no_valid", {63'd0, bus.disto_valid}, 64'd0);
    for (int i = 0; i < 16; i++) send(1'b1, 1'b1, 320, 0);
    wait_result("abort_out", 160, 1'b0);
    chk("abort_out_one_valid", 64'(valid_cnt - v0), 64'd1);

    // Reset mid-accumulation with err already set.
    start_job(256);
    send(1'b1, 1'b0, 1000, 0);
    send(1'b1, 1'b0, 1000, 0);
    send(1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1000, 0);
    rst_n = 1'b0;
    tick();
    chk("midrst_disto", {32'd0, bus.disto}, 64'd0);
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_err", {63'd0, bus.err}, 64'd0);
    chk("midrst_valid", {63'd0, bus.disto_valid}, 64'd0);
    rst_n = 1'b1;
    v0 = valid_cnt;
    repeat (10) tick();
    chk("midrst_no_valid", 64'(valid_cnt - v0), 64'd0);

    // Randomized jobs with mixed pair timing.
    for (int j = 0; j < 8; j++) begin
      tl = int'($urandom_range(0, 65535));
      qa.delete();
      qb.delete();
      start_job(tl);
      for (int i = 0; i < 16; i++) begin
        if (j % 2 == 0) begin
          a = int'($urandom);
          b = int'($urandom);
        end else begin
          a = int'($urandom_range(0, 8000)) - 4000;
          b = int'($urandom_range(0, 8000)) - 4000;
        end
        qa.push_back(a);
        qb.push_back(b);
        case ($urandom_range(0, 2))
          0: send(1'b1, 1'b1, a, b);
          1: begin
            send(1'b1, 1'b0, a, 0);
            repeat ($urandom_range(0, 3)) tick();
            send(1'b0, 1'b1, 0, b);
          end
          default: begin
            send(1'b0, 1'b1, 0, b);
            repeat ($urandom_range(0, 3)) tick();
            send(1'b1, 1'b0, a, 0);
          end
        endcase
      end
      wait_result($sformatf("rand%0d", j), model_disto(longint'(tl)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tdisto_accum.md
# tdisto_accum

Accumulates the spectral (Hadamard-weighted) distortion of one macroblock from two parallel 4x4 weighted-transform stages: one fed with source pixels (A), one with reconstructed pixels (B). Each 4x4 block contributes |sum_a − sum_b| >> 5. After BLOCK_NUM blocks the total is scaled by tlambda, rounded, and presented as a single-cycle result for the mode-decision logic.

## Interface
- BLOCK_NUM, 16, number of 4x4 block pairs per accumulation (2..64)
- ACC_WIDTH, 32, unsigned accumulator width (saturating)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a new accumulation and samples tlambda
- tlambda  in  16  unsigned distortion weight
- sum_a  in  32  signed weighted sum, source-side transform
- done_a  in  1  one-cycle valid pulse for sum_a
- sum_b  in  32  signed weighted sum, reconstruction-side transform
- done_b  in  1  one-cycle valid pulse for sum_b
- busy  out  1  accumulation in progress
- disto  out  32  unsigned scaled distortion, held until next result
- disto_valid  out  1  one-cycle pulse when disto updates
- err  out  1  sticky overrun flag, cleared by start

## Operation
- FSM states: IDLE, ACC, MUL, OUT.
- IDLE: start → ACC. Clear acc, block counter, pending flags, abs stage, and err; latch tlambda. done_a/done_b ignored while in IDLE.
- ACC, capture: on done_a, latch sum_a and set pend_a. On done_b, latch sum_b and set pend_b. Each side is independent; done_a and done_b need not coincide.
- ACC, overrun: done_x while pend_x is set and not being consumed that cycle → new value dropped, err set.
- ACC, consume: when pend_a && pend_b, register abs_q = |sum_a − sum_b| >> 5 and clear both flags. The difference is computed at 33 bits signed; the shift is applied to the magnitude, so it truncates toward zero.
- ACC, simultaneous consume and new done: the same edge clears the flag and recaptures it, so the flag stays set. This is not an overrun.
- ACC, accumulate: the cycle after consume, acc ← min(acc + abs_q, 2^ACC_WIDTH − 1) and the counter increments. When the counter reaches BLOCK_NUM → MUL.
- MUL: prod ← acc × tlambda_q, unsigned at ACC_WIDTH+16 bits, registered. → OUT.
- OUT: disto ← min((prod + 128) >> 8, 0xFFFFFFFF). disto_valid = 1 for one cycle. → IDLE.
- start in ACC, MUL, or OUT: abort. Restart exactly as from IDLE; no disto_valid is produced for the aborted run.
- busy = 1 in ACC, MUL, and OUT.

## Timing
- Reset (rst_n low at a clk edge): state IDLE. disto = 0, disto_valid = 0, busy = 0, err = 0. All internal registers are zeroed. Reset mid-run discards everything.
- Pipeline from the edge sampling the later of the pair's done pulses (E0):
  - E1: abs_q latched
  - E2: acc updated
  - For the final pair, E3: prod latched
  - E4: disto latched, disto_valid high for the cycle after E4
  - Result latency: 4 cycles from the last done cycle.
- Throughput: one pair per cycle sustained with no err.
- busy rises the cycle after start and falls the cycle after disto_valid.
- disto holds its value until the next OUT or reset.

## Test plan
- **Constant pairs:** BLOCK_NUM=16, tlambda=256, 16 coincident pairs sum_a=1000, sum_b=360. Each block gives 20; acc=320 → disto=320, disto_valid exactly 4 cycles after the last done, err=0.
- **Negative difference and rounding:** sum_a=−100, sum_b=100 (200>>5=6) ×16, tlambda=100. acc=96 → disto=(9600+128)>>8=38.
- **Staggered and overrun:**
  - Staggered: done_a at t, done_b at t+3 → pair consumed, correct contribution.
  - Overrun: two done_a with no done_b between → err=1, second sum_a dropped. The final disto reflects the first value only.
- **Back-to-back:** 16 pairs on consecutive cycles, varied values. disto equals the software model, no err, busy deasserts one cycle after disto_valid.
- **Abort and reset:**
  - Abort: start after 7 pairs, then 16 new pairs (each 10) → disto reflects only the new 16 (tlambda=256 → 160).
  - Reset: rst_n low mid-ACC → all outputs 0 at the next edge and no disto_valid.
- **Saturation:** sum_a=0x7FFFFFFF, sum_b=0x80000000 ×16 → 134217727 per block, acc=2147483632. With tlambda=65535, disto=0xFFFFFFFF.
